ram_dp_sr_sw: RTL and testbench

Synchronous true dual-port RAM with two independent read/write ports, per-byte write enables, a selectable read-during-write mode, an optional output register stage and a power-on clear engine. It is the clocked, parametrised successor to the team's asynchronous dual-port RAM. It serves as the general-purpose on-chip buffer for datapath blocks that need deterministic read latency and defined collision behaviour.

---
 rtl/ram_dp_pkg.sv | 22 ++
 rtl/ram_dp_rd_pipe.sv | 52 +++++
 rtl/ram_dp_sr_sw.sv | 166 ++++++++++++++++
 tb/tb_ram_dp_sr_sw.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// Shared constants, clear-FSM states and byte-merge helper
// for the synchronous true dual-port RAM.
package ram_dp_pkg;

   localparam int READ_FIRST  = 0;
   localparam int WRITE_FIRST = 1;

   typedef enum logic [1:0] {
      S_RESET,
      S_CLEAR,
      S_READY
   } clr_state_t;

   function automatic logic [7:0] be_merge(
      input logic [7:0] i_old,
      input logic [7:0] i_new,
      input logic       i_be
   );
      return i_be ? i_new : i_old;
   endfunction

endpackage

// File: rtl/ram_dp_rd_pipe.sv
// Read-response register for one RAM port, with an optional
// second stage that stretches read latency from 1 to 2.
module ram_dp_rd_pipe
   import ram_dp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic                  r_v1;
   logic [DATA_WIDTH-1:0] r_d1;

   // data only loads on a response so it holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_d1 <= '0;
      end else begin
         r_v1 <= i_valid;
         if (i_valid) r_d1 <= i_data;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] r_d2;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v2 <= 1'b0;
            r_d2 <= '0;
         end else begin
            r_v2 <= r_v1;
            if (r_v1) r_d2 <= r_d1;
         end
      end

      assign o_valid = r_v2;
      assign o_data  = r_d2;
   end else begin : g_noreg
      assign o_valid = r_v1;
      assign o_data  = r_d1;
   end

endmodule

// File: rtl/ram_dp_sr_sw.sv
// Synchronous true dual-port RAM: byte enables, selectable
// read-during-write mode, optional output stage, power-on clear.
module ram_dp_sr_sw
   import ram_dp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int READ_MODE  = 0,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cs_0,
   input  logic                    we_0,
   input  logic [DATA_WIDTH/8-1:0] be_0,
   input  logic [ADDR_WIDTH-1:0]   address_0,
   input  logic [DATA_WIDTH-1:0]   wdata_0,
   output logic [DATA_WIDTH-1:0]   rdata_0,
   output logic                    rvalid_0,
   input  logic                    cs_1,
   input  logic                    we_1,
   input  logic [DATA_WIDTH/8-1:0] be_1,
   input  logic [ADDR_WIDTH-1:0]   address_1,
   input  logic [DATA_WIDTH-1:0]   wdata_1,
   output logic [DATA_WIDTH-1:0]   rdata_1,
   output logic                    rvalid_1,
   output logic                    collision,
   output logic                    init_busy
);

   localparam int NB        = DATA_WIDTH / 8;
   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam bit P_CLR     = (INIT_CLEAR != 0);
   localparam bit P_WF      = (READ_MODE == WRITE_FIRST);

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

   clr_state_t            r_state;
   clr_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic                  w_clr_we;
   logic                  w_busy;
   logic                  r_coll;

   logic                  w_acc0;
   logic                  w_acc1;
   logic                  w_wr0;
   logic                  w_wr1;
   logic                  w_coll;
   logic [DATA_WIDTH-1:0] w_old0;
   logic [DATA_WIDTH-1:0] w_old1;
   logic [DATA_WIDTH-1:0] w_m0;
   logic [DATA_WIDTH-1:0] w_m1;
   logic [DATA_WIDTH-1:0] w_mc;
   logic [DATA_WIDTH-1:0] w_new0;
   logic [DATA_WIDTH-1:0] w_new1;
   logic [DATA_WIDTH-1:0] w_rsp0;
   logic [DATA_WIDTH-1:0] w_rsp1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RESET;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_we    = 1'b0;
      unique case (r_state)
         S_RESET: begin
            w_cnt_nxt   = '0;
            w_state_nxt = P_CLR ? S_CLEAR : S_READY;
         end
         S_CLEAR: begin
            w_clr_we  = 1'b1;
            w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
            if (r_cnt == {ADDR_WIDTH{1'b1}})
               w_state_nxt = S_READY;
         end
         default: w_state_nxt = S_READY;
      endcase
   end

   // RESET only counts as busy when a clear is about to follow
   assign w_busy    = (r_state == S_CLEAR) ||
                      (r_state == S_RESET && P_CLR);
   assign init_busy = w_busy;

   assign w_acc0 = cs_0 & ~w_busy;
   assign w_acc1 = cs_1 & ~w_busy;
   assign w_wr0  = w_acc0 & we_0;
   assign w_wr1  = w_acc1 & we_1;
   assign w_coll = w_wr0 & w_wr1 & (address_0 == address_1);

   assign w_old0 = r_mem[address_0];
   assign w_old1 = r_mem[address_1];

   // port 0 bytes overlay port 1's merged word on a collision
   always_comb begin
      w_m0 = '0;
      w_m1 = '0;
      w_mc = '0;
      for (int i = 0; i < NB; i++) begin
         w_m0[8*i +: 8] = be_merge(w_old0[8*i +: 8],
                                   wdata_0[8*i +: 8], be_0[i]);
         w_m1[8*i +: 8] = be_merge(w_old1[8*i +: 8],
                                   wdata_1[8*i +: 8], be_1[i]);
         w_mc[8*i +: 8] = be_merge(w_m1[8*i +: 8],
                                   wdata_0[8*i +: 8], be_0[i]);
      end
   end

   assign w_new0 = w_coll ? w_mc : w_m0;
   assign w_new1 = w_coll ? w_mc : w_m1;

   assign w_rsp0 = (we_0 && P_WF) ? w_new0 : w_old0;
   assign w_rsp1 = (we_1 && P_WF) ? w_new1 : w_old1;

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_cnt] <= '0;
      end else begin
         if (w_wr1 && !w_coll) r_mem[address_1] <= w_m1;
         if (w_wr0)            r_mem[address_0] <= w_new0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_coll <= 1'b0;
      else        r_coll <= w_coll;
   end

   assign collision = r_coll;

   ram_dp_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
   ) u_pipe_0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_acc0),
      .i_data  (w_rsp0),
      .o_valid (rvalid_0),
      .o_data  (rdata_0)
   );

   ram_dp_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
   ) u_pipe_1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_acc1),
      .i_data  (w_rsp1),
      .o_valid (rvalid_1),
      .o_data  (rdata_1)
   );

endmodule

// File: tb/tb_ram_dp_sr_sw.sv
// Directed bench: READ_FIRST/latency-1 and WRITE_FIRST/latency-2
// instances share one stimulus stream.
module tb_ram_dp_sr_sw;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs_0, we_0, cs_1, we_1;
   logic [3:0]  be_0, be_1;
   logic [7:0]  address_0, address_1;
   logic [31:0] wdata_0, wdata_1;

   logic [31:0] rdata_0_a, rdata_1_a, rdata_0_b, rdata_1_b;
   logic        rvalid_0_a, rvalid_1_a, rvalid_0_b, rvalid_1_b;
   logic        coll_a, coll_b, busy_a, busy_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_dp_sr_sw #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_MODE(0),
      .OUT_REG(0), .INIT_CLEAR(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .cs_0(cs_0), .we_0(we_0), .be_0(be_0),
      .address_0(address_0), .wdata_0(wdata_0),
      .rdata_0(rdata_0_a), .rvalid_0(rvalid_0_a),
      .cs_1(cs_1), .we_1(we_1), .be_1(be_1),
      .address_1(address_1), .wdata_1(wdata_1),
      .rdata_1(rdata_1_a), .rvalid_1(rvalid_1_a),
      .collision(coll_a), .init_busy(busy_a)
   );

   ram_dp_sr_sw #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_MODE(1),
      .OUT_REG(1), .INIT_CLEAR(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .cs_0(cs_0), .we_0(we_0), .be_0(be_0),
      .address_0(address_0), .wdata_0(wdata_0),
      .rdata_0(rdata_0_b), .rvalid_0(rvalid_0_b),
      .cs_1(cs_1), .we_1(we_1), .be_1(be_1),
      .address_1(address_1), .wdata_1(wdata_1),
      .rdata_1(rdata_1_b), .rvalid_1(rvalid_1_b),
      .collision(coll_b), .init_busy(busy_b)
   );

   typedef struct {
      logic        cs0, we0;
      logic [3:0]  be0;
      logic [7:0]  a0;
      logic [31:0] d0;
      logic        cs1, we1;
      logic [3:0]  be1;
      logic [7:0]  a1;
      logic [31:0] d1;
      logic        rv0;
      logic [31:0] ra0, rb0;
      logic        rv1;
      logic [31:0] ra1, rb1;
      logic        col;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mkv(
      input logic c0, w0, input logic [3:0] b0,
      input logic [7:0] a0, input logic [31:0] d0,
      input logic c1, w1, input logic [3:0] b1,
      input logic [7:0] a1, input logic [31:0] d1,
      input logic v0, input logic [31:0] ra0, rb0,
      input logic v1, input logic [31:0] ra1, rb1,
      input logic col
   );
      vec_t v;
      v.cs0 = c0; v.we0 = w0; v.be0 = b0; v.a0 = a0; v.d0 = d0;
      v.cs1 = c1; v.we1 = w1; v.be1 = b1; v.a1 = a1; v.d1 = d1;
      v.rv0 = v0; v.ra0 = ra0; v.rb0 = rb0;
      v.rv1 = v1; v.ra1 = ra1; v.rb1 = rb1;
      v.col = col;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      cs_0 = 1'b0; we_0 = 1'b0; be_0 = '0; address_0 = '0; wdata_0 = '0;
      cs_1 = 1'b0; we_1 = 1'b0; be_1 = '0; address_1 = '0; wdata_1 = '0;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      @(negedge clk);
      cs_0 = v.cs0; we_0 = v.we0; be_0 = v.be0;
      address_0 = v.a0; wdata_0 = v.d0;
      cs_1 = v.cs1; we_1 = v.we1; be_1 = v.be1;
      address_1 = v.a1; wdata_1 = v.d1;
      @(posedge clk); #1;
      chk($sformatf("v%0d a.rvalid_0", k), 32'(rvalid_0_a), 32'(v.rv0));
      chk($sformatf("v%0d a.rvalid_1", k), 32'(rvalid_1_a), 32'(v.rv1));
      if (v.rv0) chk($sformatf("v%0d a.rdata_0", k), rdata_0_a, v.ra0);
      if (v.rv1) chk($sformatf("v%0d a.rdata_1", k), rdata_1_a, v.ra1);
      chk($sformatf("v%0d a.collision", k), 32'(coll_a), 32'(v.col));
      chk($sformatf("v%0d b.collision", k), 32'(coll_b), 32'(v.col));
      chk($sformatf("v%0d b.rvalid_0 early", k), 32'(rvalid_0_b), 32'(0));
      chk($sformatf("v%0d b.rvalid_1 early", k), 32'(rvalid_1_b), 32'(0));
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk($sformatf("v%0d b.rvalid_0", k), 32'(rvalid_0_b), 32'(v.rv0));
      chk($sformatf("v%0d b.rvalid_1", k), 32'(rvalid_1_b), 32'(v.rv1));
      if (v.rv0) chk($sformatf("v%0d b.rdata_0", k), rdata_0_b, v.rb0);
      if (v.rv1) chk($sformatf("v%0d b.rdata_1", k), rdata_1_b, v.rb1);
      chk($sformatf("v%0d a.rvalid_0 pulse", k), 32'(rvalid_0_a), 32'(0));
      chk($sformatf("v%0d a.rvalid_1 pulse", k), 32'(rvalid_1_a), 32'(0));
      chk($sformatf("v%0d a.collision pulse", k), 32'(coll_a), 32'(0));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " a.rdata_0"}, rdata_0_a, 32'h0);
      chk({tag, " a.rdata_1"}, rdata_1_a, 32'h0);
      chk({tag, " a.rvalid_0"}, 32'(rvalid_0_a), 32'(0));
      chk({tag, " a.rvalid_1"}, 32'(rvalid_1_a), 32'(0));
      chk({tag, " a.collision"}, 32'(coll_a), 32'(0));
      chk({tag, " a.init_busy"}, 32'(busy_a), 32'(1));
      chk({tag, " b.rdata_0"}, rdata_0_b, 32'h0);
      chk({tag, " b.rvalid_0"}, 32'(rvalid_0_b), 32'(0));
      chk({tag, " b.init_busy"}, 32'(busy_b), 32'(1));
   endtask

   initial begin
      int  n_busy;
      bit  done;

      tbl[0]  = mkv(1,0,4'h0,8'h10,32'h0, 1,0,4'h0,8'h11,32'h0,
                    1,32'h0,32'h0, 1,32'h0,32'h0, 0);
      tbl[1]  = mkv(1,1,4'hF,8'h05,32'hDEADBEEF, 0,0,4'h0,8'h00,32'h0,
                    1,32'h0,32'hDEADBEEF, 0,32'h0,32'h0, 0);
      tbl[2]  = mkv(1,1,4'h5,8'h05,32'h11223344, 0,0,4'h0,8'h00,32'h0,
                    1,32'hDEADBEEF,32'hDE22BE44, 0,32'h0,32'h0, 0);
      tbl[3]  = mkv(0,0,4'h0,8'h00,32'h0, 1,0,4'h0,8'h05,32'h0,
                    0,32'h0,32'h0, 1,32'hDE22BE44,32'hDE22BE44, 0);
      tbl[4]  = mkv(1,1,4'hF,8'h07,32'hAAAAAAAA, 0,0,4'h0,8'h00,32'h0,
                    1,32'h0,32'hAAAAAAAA, 0,32'h0,32'h0, 0);
      tbl[5]  = mkv(1,1,4'hF,8'h07,32'h55555555, 1,0,4'h0,8'h07,32'h0,
                    1,32'hAAAAAAAA,32'h55555555,
                    1,32'hAAAAAAAA,32'hAAAAAAAA, 0);
      tbl[6]  = mkv(1,0,4'h0,8'h05,32'h0, 1,0,4'h0,8'h07,32'h0,
                    1,32'hDE22BE44,32'hDE22BE44,
                    1,32'h55555555,32'h55555555, 0);
      tbl[7]  = mkv(1,1,4'h3,8'h20,32'h000000FF,
                    1,1,4'hF,8'h20,32'h12345678,
                    1,32'h0,32'h123400FF, 1,32'h0,32'h123400FF, 1);
      tbl[8]  = mkv(1,0,4'h0,8'h20,32'h0, 0,0,4'h0,8'h00,32'h0,
                    1,32'h123400FF,32'h123400FF, 0,32'h0,32'h0, 0);
      tbl[9]  = mkv(1,1,4'h1,8'h21,32'h000000AA,
                    1,1,4'h8,8'h21,32'hBB000000,
                    1,32'h0,32'hBB0000AA, 1,32'h0,32'hBB0000AA, 1);
      tbl[10] = mkv(1,1,4'h0,8'h22,32'hFFFFFFFF, 1,0,4'h0,8'h21,32'h0,
                    1,32'h0,32'h0, 1,32'hBB0000AA,32'hBB0000AA, 0);
      tbl[11] = mkv(1,0,4'h0,8'h22,32'h0, 1,1,4'hC,8'h23,32'h98765432,
                    1,32'h0,32'h0, 1,32'h0,32'h98760000, 0);
      tbl[12] = mkv(0,0,4'h0,8'h00,32'h0, 1,0,4'h0,8'h23,32'h0,
                    0,32'h0,32'h0, 1,32'h98760000,32'h98760000, 0);
      tbl[13] = mkv(1,0,4'h0,8'h30,32'h0, 1,1,4'hF,8'h30,32'hCAFEF00D,
                    1,32'h0,32'h0, 1,32'h0,32'hCAFEF00D, 0);
      tbl[14] = mkv(1,1,4'hF,8'h40,32'h01020304,
                    1,1,4'hF,8'h41,32'h05060708,
                    1,32'h0,32'h01020304, 1,32'h0,32'h05060708, 0);
      tbl[15] = mkv(1,0,4'h0,8'h41,32'h0, 1,0,4'h0,8'h40,32'h0,
                    1,32'h05060708,32'h05060708,
                    1,32'h01020304,32'h01020304, 0);
      tbl[16] = mkv(1,0,4'h0,8'h30,32'h0, 0,0,4'h0,8'h00,32'h0,
                    1,32'hCAFEF00D,32'hCAFEF00D, 0,32'h0,32'h0, 0);

      rst_n = 1'b0;
      idle();
      #12;
      chk_reset("por");

      // abort the clear at count 100
      @(negedge clk);
      rst_n = 1'b1;
      repeat (101) @(posedge clk);
      #2;
      chk("midclear busy before abort", 32'(busy_a), 32'(1));
      rst_n = 1'b0;
      #1;
      chk_reset("abort");

      @(negedge clk);
      rst_n = 1'b1;
      n_busy = 0;
      done   = 1'b0;
      for (int e = 0; e < 400 && !done; e++) begin
         @(posedge clk); #1;
         if (busy_a) n_busy++;
         else        done = 1'b1;
         if (e == 10)
            chk("drop a.rvalid_0", 32'(rvalid_0_a), 32'(0));
         if (e == 11)
            chk("drop b.rvalid_0", 32'(rvalid_0_b), 32'(0));
         if (e == 9) begin
            cs_0 = 1'b1; we_0 = 1'b1; be_0 = 4'hF;
            address_0 = 8'h10; wdata_0 = 32'hCAFEBABE;
         end else begin
            idle();
         end
      end
      chk("clear busy cycles", 32'(n_busy), 32'd256);
      chk("clear b.init_busy done", 32'(busy_b), 32'(0));

      for (int k = 0; k < 17; k++)
         run_vec(k, tbl[k]);

      // back-to-back write then reads, and rdata hold
      @(negedge clk);
      cs_0 = 1'b1; we_0 = 1'b1; be_0 = 4'hF;
      address_0 = 8'h50; wdata_0 = 32'h11111111;
      @(posedge clk); #1;
      chk("b2b e1 a.rvalid_0", 32'(rvalid_0_a), 32'(1));
      chk("b2b e1 a.rdata_0", rdata_0_a, 32'h0);
      @(negedge clk);
      we_0 = 1'b0; be_0 = '0; wdata_0 = '0;
      cs_1 = 1'b1; we_1 = 1'b0; address_1 = 8'h50;
      @(posedge clk); #1;
      chk("b2b e2 a.rdata_0", rdata_0_a, 32'h11111111);
      chk("b2b e2 a.rvalid_1", 32'(rvalid_1_a), 32'(1));
      chk("b2b e2 a.rdata_1", rdata_1_a, 32'h11111111);
      chk("b2b e2 b.rvalid_0", 32'(rvalid_0_b), 32'(1));
      chk("b2b e2 b.rdata_0", rdata_0_b, 32'h11111111);
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk("b2b e3 a.rvalid_0", 32'(rvalid_0_a), 32'(0));
      chk("b2b e3 a.rdata_0 hold", rdata_0_a, 32'h11111111);
      chk("b2b e3 b.rvalid_0", 32'(rvalid_0_b), 32'(1));
      chk("b2b e3 b.rvalid_1", 32'(rvalid_1_b), 32'(1));
      chk("b2b e3 b.rdata_1", rdata_1_b, 32'h11111111);
      @(posedge clk); #1;
      chk("b2b e4 b.rvalid_0", 32'(rvalid_0_b), 32'(0));
      chk("b2b e4 b.rdata_0 hold", rdata_0_b, 32'h11111111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
